prbs_checker: RTL and testbench
===============================

// Module: prbs_checker
// PURPOSE
//  Serial PRBS receiver/checker for the stream produced by the team's 5-bit LFSR
//  generator (x^5+x^3+1; each cycle the generator emits its inserted feedback bit).
//  Self-synchronises on the incoming bit stream, declares lock, then flags bit errors.
//  Sits at the sink end of BIST/link-test paths, opposite the LFSR source.
// PARAMETERS
//  WIDTH     5         LFSR length; shift-register width
//  TAPS      5'b10100  tap mask over sr; expected = ^(sr & TAPS) (sr[4]^sr[2] by default)
//  LOCK_CNT  8         consecutive matches in SEEK required to assert locked
//  LOSS_CNT  4         mismatches, without WIDTH clean bits in between, that drop lock
// PORTS
//  clk        in   1   clock, rising edge
//  reset_n    in   1   asynchronous reset, active low
//  in_valid   in   1   in_bit is valid this cycle; when low all state holds
//  in_bit     in   1   received serial PRBS bit
//  locked     out  1   checker synchronised to stream
//  err        out  1   one-cycle pulse: last valid bit mismatched while LOCKED
//  err_count  out  16  saturating error count (see CONFIGURATION)
//  bit_count  out  16  saturating count of valid bits checked while LOCKED
//  cnt_clr    in   1   synchronous clear of err_count/bit_count
// BEHAVIOUR
//  - Reset (reset_n=0, async): sr=0, state=FILL, all counters 0; locked=0, err=0,
//    err_count=0, bit_count=0. Resetting mid-operation aborts lock immediately.
//  - sr[0] = newest bit. On every valid bit: exp = ^(sr & TAPS) (pre-shift sr);
//    match = (in_bit == exp); then sr <= {sr[WIDTH-2:0], in_bit}. The received bit
//    always shifts in (never the prediction), so the checker self-resyncs.
//  - FSM, advancing on valid bits only:
//    FILL  : count WIDTH valid bits, no compare -> SEEK.
//    SEEK  : match with post-shift sr != 0 -> run_cnt+1; mismatch -> run_cnt=0;
//            post-shift sr==0 -> run_cnt=0 (all-zero lock-up never locks).
//            run_cnt==LOCK_CNT -> LOCKED, miss_cnt=0, zero_run=0.
//    LOCKED: mismatch -> err=1 next cycle, miss_cnt+1, clean_cnt=0;
//            match -> clean_cnt+1; clean_cnt==WIDTH -> miss_cnt=0.
//            miss_cnt reaching LOSS_CNT -> SEEK (run_cnt=0); that bit still pulses err.
//            WIDTH consecutive 0 bits received -> SEEK (illegal in a maximal sequence).
//  - Outputs registered: locked goes 1 in the cycle after the LOCK_CNT-th matching
//    bit; err is high exactly one cycle per mismatching valid bit.
//  - Default lock latency after reset: WIDTH+LOCK_CNT = 13 valid bits.
//  - On SEEK re-entry sr is kept, so FILL is not repeated; relock in LOCK_CNT bits.
//  - A single flipped bit yields up to popcount(TAPS)+1 = 3 err pulses (default).
//  - Counters saturate at 16'hFFFF. cnt_clr wins over a same-cycle increment.
// CONFIGURATION
//  PRBS_CHK_COUNTERS_EN defined: err_count increments on each err event,
//    bit_count on each valid bit checked in LOCKED; cnt_clr active.
//  Not defined: no counter flops; err_count and bit_count tied to 0; cnt_clr ignored.
//    locked/err behaviour identical in both builds.
// TESTING  (reference model: generator seeded 5'b00001, stream = fb bit 0,0,1,...)
//  1 reset, 40 continuous valid bits -> locked=1 in cycle after 13th bit; err never 1.
//  2 locked, flip bit 20 -> err pulses on bits 20,23,25; err_count=3; locked stays 1.
//  3 same stream, in_valid randomly low 50% -> identical locked/err sequence per bit;
//    no state change on invalid cycles.
//  4 locked, drive 5 zeros -> locked=0 after 5th; then 20 more zeros -> never relocks.
//  5 locked, 64 random bits -> locked=0; resume PRBS -> relock after exactly 8 matches.
//  6 reset_n low mid-lock (async, between edges) -> locked/err/counters 0 at once; FILL;
//    with COUNTERS_EN: 70000 locked bits -> bit_count=16'hFFFF; cnt_clr -> 0.

Source files
------------

// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising serial PRBS checker for the 5-bit LFSR source
// (x^5+x^3+1). Fills its shift register from the stream, waits for a run of
// correctly predicted bits before declaring lock, then flags every bit that
// disagrees with the prediction. The received bit is always shifted in, so a
// single line error produces a short burst of err pulses and then clears.
// Optional build macro: PRBS_CHK_COUNTERS_EN adds the saturating error/bit
// counters and cnt_clr; without it the counter outputs are tied to zero.
module prbs_checker #(
    parameter int unsigned      WIDTH    = 5,
    parameter logic [WIDTH-1:0] TAPS     = 5'b10100,
    parameter int unsigned      LOCK_CNT = 8,
    parameter int unsigned      LOSS_CNT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic        in_bit,
    input  logic        cnt_clr,
    output logic        locked,
    output logic        err,
    output logic [15:0] err_count,
    output logic [15:0] bit_count
);

    localparam int unsigned FILL_W = $clog2(WIDTH + 1);
    localparam int unsigned RUN_W  = $clog2(LOCK_CNT + 1);
    localparam int unsigned MISS_W = $clog2(LOSS_CNT + 1);

    localparam logic [FILL_W-1:0] WIDTH_V = FILL_W'(WIDTH);
    localparam logic [RUN_W-1:0]  LOCK_V  = RUN_W'(LOCK_CNT);
    localparam logic [MISS_W-1:0] LOSS_V  = MISS_W'(LOSS_CNT);

    typedef enum logic [1:0] {
        S_FILL,
        S_SEEK,
        S_LOCKED
    } state_e;

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    sr_q, sr_d;
    logic [FILL_W-1:0]   fill_q, fill_d;    // bits loaded since reset
    logic [RUN_W-1:0]    run_q, run_d;      // consecutive good predictions in SEEK
    logic [MISS_W-1:0]   miss_q, miss_d;    // recent mismatches in LOCKED
    logic [FILL_W-1:0]   clean_q, clean_d;  // matches since the last mismatch
    logic [FILL_W-1:0]   zero_q, zero_d;    // consecutive zero bits in LOCKED
    logic                locked_q, locked_d;
    logic                err_q, err_d;

    logic                exp_bit;
    logic                match;
    logic [WIDTH-1:0]    sr_shift;

    // Next-state logic: prediction, shift-in of the received bit and the FILL/SEEK/LOCKED walk.
    always_comb begin
        // NOTE: every _d gets its hold value first, so no path through this block can infer a latch.
        state_d = state_q;
        sr_d    = sr_q;
        fill_d  = fill_q;
        run_d   = run_q;
        miss_d  = miss_q;
        clean_d = clean_q;
        zero_d  = zero_q;
        err_d   = 1'b0;

        exp_bit  = ^(sr_q & TAPS);
        match    = (in_bit == exp_bit);
        sr_shift = {sr_q[WIDTH-2:0], in_bit};

        if (in_valid) begin
            sr_d = sr_shift;
            case (state_q)
                S_FILL: begin
                    fill_d = fill_q + FILL_W'(1);
                    if (fill_d == WIDTH_V) begin
                        state_d = S_SEEK;
                        run_d   = '0;
                    end
                end
                S_SEEK: begin
                    // An all-zero register predicts zeros forever; never count that as progress.
                    if (!match || sr_shift == '0) begin
                        run_d = '0;
                    end else begin
                        run_d = run_q + RUN_W'(1);
                    end
                    if (run_d == LOCK_V) begin
                        state_d = S_LOCKED;
                        miss_d  = '0;
                        clean_d = '0;
                        zero_d  = '0;
                    end
                end
                S_LOCKED: begin
                    if (!match) begin
                        err_d   = 1'b1;
                        miss_d  = miss_q + MISS_W'(1);
                        clean_d = '0;
                    end else begin
                        if (clean_q != WIDTH_V) begin
                            clean_d = clean_q + FILL_W'(1);
                        end
                        if (clean_d == WIDTH_V) begin
                            miss_d = '0;
                        end
                    end
                    zero_d = in_bit ? '0 : zero_q + FILL_W'(1);
                    // sr is kept on the way back to SEEK, so no refill is needed.
                    if (miss_d == LOSS_V || zero_d == WIDTH_V) begin
                        state_d = S_SEEK;
                        run_d   = '0;
                    end
                end
                default: state_d = S_FILL;
            endcase
        end

        locked_d = (state_d == S_LOCKED);
    end

    // Checker state and registered outputs; reset drops lock immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_FILL;
            sr_q     <= '0;
            fill_q   <= '0;
            run_q    <= '0;
            miss_q   <= '0;
            clean_q  <= '0;
            zero_q   <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge values computed above.
            state_q  <= state_d;
            sr_q     <= sr_d;
            fill_q   <= fill_d;
            run_q    <= run_d;
            miss_q   <= miss_d;
            clean_q  <= clean_d;
            zero_q   <= zero_d;
            locked_q <= locked_d;
            err_q    <= err_d;
        end
    end

    assign locked = locked_q;
    assign err    = err_q;

`ifdef PRBS_CHK_COUNTERS_EN
    logic [15:0] err_count_q, err_count_d;
    logic [15:0] bit_count_q, bit_count_d;

    // Counter next values: clear beats a same-cycle increment, both saturate at all-ones.
    always_comb begin
        err_count_d = err_count_q;
        bit_count_d = bit_count_q;
        if (cnt_clr) begin
            err_count_d = '0;
            bit_count_d = '0;
        end else begin
            if (err_d && err_count_q != 16'hFFFF) begin
                err_count_d = err_count_q + 16'd1;
            end
            if (in_valid && state_q == S_LOCKED && bit_count_q != 16'hFFFF) begin
                bit_count_d = bit_count_q + 16'd1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_count_q <= '0;
            bit_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
            bit_count_q <= bit_count_d;
        end
    end

    assign err_count = err_count_q;
    assign bit_count = bit_count_q;
`else
    // Counters are absent in this build; cnt_clr has nothing to clear.
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign err_count      = '0;
    assign bit_count      = '0;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: randomized self-checking bench for prbs_checker. A reference
// generator (x^5+x^3+1, seeded 5'b00001) produces the stream and a behavioural
// model built from the stream history predicts locked/err/counters per bit.
module tb_prbs_checker;

    localparam int WIDTH    = 5;
    localparam int LOCK_CNT = 8;
    localparam int LOSS_CNT = 4;
`ifdef PRBS_CHK_COUNTERS_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    localparam int M_FILL = 0;
    localparam int M_SEEK = 1;
    localparam int M_LOCK = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_bit;
    logic        cnt_clr;
    logic        locked;
    logic        err;
    logic [15:0] err_count;
    logic [15:0] bit_count;

    int n_checks = 0;
    int n_fail   = 0;

    prbs_checker dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .cnt_clr   (cnt_clr),
        .locked    (locked),
        .err       (err),
        .err_count (err_count),
        .bit_count (bit_count)
    );

    always #5 clk = ~clk;

    // ---------------- reference generator ----------------
    bit g_hist[$];  // last WIDTH emitted bits, oldest first

    task automatic gen_reset();
        g_hist.delete();
        repeat (WIDTH - 1) g_hist.push_back(1'b0);
        g_hist.push_back(1'b1);
    endtask

    // Recurrence of x^5+x^3+1: new bit = bit five back XOR bit three back.
    task automatic gen_next(output bit b);
        b = g_hist[g_hist.size() - 5] ^ g_hist[g_hist.size() - 3];
        g_hist.push_back(b);
        void'(g_hist.pop_front());
    endtask

    // ---------------- behavioural checker model ----------------
    bit          m_hist[$];
    int          m_mode, m_fill, m_run, m_miss, m_clean, m_zero;
    bit          m_locked, m_err;
    logic [15:0] m_errc, m_bitc;

    function automatic bit hist_bit(input int k);
        if (m_hist.size() >= k) return m_hist[m_hist.size() - k];
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_hist.delete();
        m_mode = M_FILL; m_fill = 0; m_run = 0; m_miss = 0; m_clean = 0; m_zero = 0;
        m_locked = 1'b0; m_err = 1'b0; m_errc = '0; m_bitc = '0;
    endtask

    task automatic model_step(input bit v, input bit b, input bit clr);
        bit pred, all_zero, was_locked;
        was_locked = (m_mode == M_LOCK);
        m_err = 1'b0;
        if (v) begin
            pred = hist_bit(5) ^ hist_bit(3);
            m_hist.push_back(b);
            if (m_hist.size() > WIDTH) void'(m_hist.pop_front());
            all_zero = 1'b1;
            foreach (m_hist[j]) if (m_hist[j]) all_zero = 1'b0;
            if (m_mode == M_FILL) begin
                m_fill++;
                if (m_fill == WIDTH) begin m_mode = M_SEEK; m_run = 0; end
            end else if (m_mode == M_SEEK) begin
                m_run = (b == pred && !all_zero) ? m_run + 1 : 0;
                if (m_run == LOCK_CNT) begin
                    m_mode = M_LOCK; m_miss = 0; m_clean = 0; m_zero = 0;
                end
            end else begin
                if (b != pred) begin m_err = 1'b1; m_miss++; m_clean = 0; end
                else begin m_clean++; if (m_clean >= WIDTH) m_miss = 0; end
                m_zero = b ? 0 : m_zero + 1;
                if (m_miss >= LOSS_CNT || m_zero >= WIDTH) begin m_mode = M_SEEK; m_run = 0; end
            end
        end
        if (CNT_EN) begin
            if (clr) begin
                m_errc = '0; m_bitc = '0;
            end else if (v) begin
                if (m_err && m_errc != 16'hFFFF) m_errc = m_errc + 16'd1;
                if (was_locked && m_bitc != 16'hFFFF) m_bitc = m_bitc + 16'd1;
            end
        end
        m_locked = (m_mode == M_LOCK);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit v, input bit b, input bit clr);
        @(negedge clk);
        in_valid = v; in_bit = b; cnt_clr = clr;
        @(posedge clk);
        #1;
        model_step(v, b, clr);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset_n = 1'b0; in_valid = 1'b0; cnt_clr = 1'b0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    bit rec_bits[1:40];
    bit rec_locked[1:40];
    bit rec_err[1:40];

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; cnt_clr = 1'b0;
        model_reset();
        #12;
        n_checks++;
        if ({locked, err} !== 2'b00) begin
            n_fail++; $display("FAIL reset_flags: locked=%b err=%b, want 0 0", locked, err);
        end
        n_checks++;
        if ({err_count, bit_count} !== 32'h0) begin
            n_fail++; $display("FAIL reset_counts: err_count=%h bit_count=%h, want 0 0", err_count, bit_count);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) drive(1'b0, 1'b1, 1'b0);
        n_checks++;
        if ({locked, err} !== 2'b00) begin
            n_fail++; $display("FAIL reset_idle: locked=%b err=%b, want 0 0", locked, err);
        end
    endtask

    task automatic test_lock();
        bit b;
        gen_reset();
        for (int i = 1; i <= 40; i++) begin
            gen_next(b);
            drive(1'b1, b, 1'b0);
            n_checks++;
            if (locked !== (i >= 13)) begin
                n_fail++; $display("FAIL lock_latency bit %0d: locked=%b want %b", i, locked, (i >= 13));
            end
            n_checks++;
            if (err !== 1'b0) begin
                n_fail++; $display("FAIL lock_err bit %0d: err=%b want 0", i, err);
            end
            n_checks++;
            if ({locked, err} !== {m_locked, m_err}) begin
                n_fail++; $display("FAIL lock_model bit %0d: got %b%b want %b%b", i, locked, err, m_locked, m_err);
            end
        end
        n_checks++;
        if ({err_count, bit_count} !== {m_errc, m_bitc}) begin
            n_fail++; $display("FAIL lock_counts: got %h/%h want %h/%h", err_count, bit_count, m_errc, m_bitc);
        end
    endtask

    task automatic test_flip();
        bit b, want_err;
        do_reset();
        gen_reset();
        for (int i = 1; i <= 40; i++) begin
            gen_next(b);
            if (i == 20) b = ~b;
            rec_bits[i] = b;
            drive(1'b1, b, 1'b0);
            rec_locked[i] = locked;
            rec_err[i]    = err;
            want_err = (i == 20 || i == 23 || i == 25);
            n_checks++;
            if (err !== want_err || locked !== (i >= 13)) begin
                n_fail++; $display("FAIL flip_pattern bit %0d: err=%b locked=%b want %b %b", i, err, locked, want_err, (i >= 13));
            end
            n_checks++;
            if ({locked, err} !== {m_locked, m_err}) begin
                n_fail++; $display("FAIL flip_model bit %0d: got %b%b want %b%b", i, locked, err, m_locked, m_err);
            end
        end
`ifdef PRBS_CHK_COUNTERS_EN
        n_checks++;
        if (err_count !== 16'd3) begin
            n_fail++; $display("FAIL flip_err_count: err_count=%0d want 3", err_count);
        end
`endif
        n_checks++;
        if ({err_count, bit_count} !== {m_errc, m_bitc}) begin
            n_fail++; $display("FAIL flip_counts: got %h/%h want %h/%h", err_count, bit_count, m_errc, m_bitc);
        end
    endtask

    task automatic test_valid_gaps();
        int  i, cyc;
        bit  prev_locked;
        do_reset();
        i = 1; cyc = 0;
        while (i <= 40 && cyc < 400) begin
            cyc++;
            if ($urandom_range(0, 1) != 0) begin
                drive(1'b1, rec_bits[i], 1'b0);
                n_checks++;
                if ({locked, err} !== {rec_locked[i], rec_err[i]}) begin
                    n_fail++; $display("FAIL gaps_seq bit %0d: got %b%b want %b%b", i, locked, err, rec_locked[i], rec_err[i]);
                end
                i++;
            end else begin
                prev_locked = locked;
                drive(1'b0, 1'($urandom), 1'b0);
                n_checks++;
                if (locked !== prev_locked || err !== 1'b0) begin
                    n_fail++; $display("FAIL gaps_hold cycle %0d: locked=%b err=%b want %b 0", cyc, locked, err, prev_locked);
                end
            end
            n_checks++;
            if ({locked, err, err_count, bit_count} !== {m_locked, m_err, m_errc, m_bitc}) begin
                n_fail++; $display("FAIL gaps_model cycle %0d: got %b%b %h %h want %b%b %h %h",
                                   cyc, locked, err, err_count, bit_count, m_locked, m_err, m_errc, m_bitc);
            end
        end
        n_checks++;
        if (i <= 40) begin
            n_fail++; $display("FAIL gaps_timeout: delivered %0d bits, want 40", i - 1);
        end
    endtask

    task automatic test_zeros();
        n_checks++;
        if (locked !== 1'b1) begin
            n_fail++; $display("FAIL zeros_pre: locked=%b want 1", locked);
        end
        for (int i = 1; i <= 25; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            n_checks++;
            if ({locked, err} !== {m_locked, m_err}) begin
                n_fail++; $display("FAIL zeros_model zero %0d: got %b%b want %b%b", i, locked, err, m_locked, m_err);
            end
            if (i >= 5) begin
                n_checks++;
                if (locked !== 1'b0) begin
                    n_fail++; $display("FAIL zeros_unlock zero %0d: locked=%b want 0", i, locked);
                end
            end
        end
    endtask

    // Feed generator bits until lock; returns how many bits it took (bounded).
    task automatic relock(input string tag, output int k);
        bit b;
        k = 0;
        while (locked !== 1'b1 && k < 30) begin
            gen_next(b);
            drive(1'b1, b, 1'b0);
            k++;
            n_checks++;
            if ({locked, err} !== {m_locked, m_err}) begin
                n_fail++; $display("FAIL %s_model bit %0d: got %b%b want %b%b", tag, k, locked, err, m_locked, m_err);
            end
        end
        n_checks++;
        if (k < LOCK_CNT || k > WIDTH + LOCK_CNT) begin
            n_fail++; $display("FAIL %s_latency: took %0d bits, want %0d..%0d", tag, k, LOCK_CNT, WIDTH + LOCK_CNT);
        end
    endtask

    task automatic test_random_loss();
        int k;
        bit seen_drop, b;
        relock("acquire", k);
        seen_drop = 1'b0;
        for (int i = 1; i <= 64; i++) begin
            b = 1'($urandom);
            drive(1'b1, b, 1'b0);
            if (!locked) seen_drop = 1'b1;
            n_checks++;
            if ({locked, err} !== {m_locked, m_err}) begin
                n_fail++; $display("FAIL random_model bit %0d: got %b%b want %b%b", i, locked, err, m_locked, m_err);
            end
        end
        n_checks++;
        if (!seen_drop) begin
            n_fail++; $display("FAIL random_loss: locked stayed 1 through 64 random bits, want a drop");
        end
        repeat (WIDTH) drive(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (locked !== 1'b0) begin
            n_fail++; $display("FAIL random_flush: locked=%b want 0", locked);
        end
        relock("resume", k);
        n_checks++;
        if ({err_count, bit_count} !== {m_errc, m_bitc}) begin
            n_fail++; $display("FAIL random_counts: got %h/%h want %h/%h", err_count, bit_count, m_errc, m_bitc);
        end
    endtask

    task automatic test_async_reset();
        bit b;
        n_checks++;
        if (locked !== 1'b1) begin
            n_fail++; $display("FAIL areset_pre: locked=%b want 1", locked);
        end
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({locked, err, err_count, bit_count} !== 34'h0) begin
            n_fail++; $display("FAIL areset_now: locked=%b err=%b cnt=%h/%h want all 0", locked, err, err_count, bit_count);
        end
        @(negedge clk);
        in_valid = 1'b0;
        reset_n  = 1'b1;
        model_reset();
        gen_reset();
        for (int i = 1; i <= 13; i++) begin
            gen_next(b);
            drive(1'b1, b, 1'b0);
            n_checks++;
            if (locked !== (i >= 13) || locked !== m_locked) begin
                n_fail++; $display("FAIL areset_refill bit %0d: locked=%b want %b", i, locked, (i >= 13));
            end
        end
`ifdef PRBS_CHK_COUNTERS_EN
        for (int i = 0; i < 70000; i++) begin
            gen_next(b);
            drive(1'b1, b, 1'b0);
        end
        n_checks++;
        if (bit_count !== 16'hFFFF || err_count !== 16'h0000) begin
            n_fail++; $display("FAIL count_saturate: bit_count=%h err_count=%h want FFFF 0000", bit_count, err_count);
        end
`endif
        gen_next(b);
        drive(1'b1, b, 1'b1);
        n_checks++;
        if ({err_count, bit_count} !== 32'h0) begin
            n_fail++; $display("FAIL count_clear: got %h/%h want 0/0", err_count, bit_count);
        end
        gen_next(b);
        drive(1'b1, b, 1'b0);
        n_checks++;
        if ({locked, err_count, bit_count} !== {1'b1, m_errc, m_bitc}) begin
            n_fail++; $display("FAIL count_resume: got %b %h/%h want 1 %h/%h", locked, err_count, bit_count, m_errc, m_bitc);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_flip();
        test_valid_gaps();
        test_zeros();
        test_random_loss();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
